// File: rtl/b01_line_gen.sv
// Serial line generator for the b01 comparator: shifts a word pair out LSB-first
// on LINE1/LINE2 together with the golden serial sum and the final carry.
module b01_line_gen #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             LINE1,
    output logic             LINE2,
    output logic             FRAME,
    output logic             EXP_SUM,
    output logic             EXP_OVERFLW,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [GW-1:0]    gcnt, gcnt_d;
    logic [WIDTH-1:0] sh1, sh1_d;
    logic [WIDTH-1:0] sh2, sh2_d;
    logic             carry, carry_d;
    logic             ready_d, line1_d, line2_d, frame_d, sum_d, ovf_d, done_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        gcnt_d  = gcnt;
        sh1_d   = sh1;
        sh2_d   = sh2;
        carry_d = carry;
        ready_d = 1'b0;
        line1_d = 1'b0;
        line2_d = 1'b0;
        frame_d = 1'b0;
        sum_d   = 1'b0;
        ovf_d   = EXP_OVERFLW;
        done_d  = 1'b0;

        case (state)
            S_IDLE: begin
                ready_d = 1'b1;
                if (LOAD_VALID) begin
                    // Bit 0 leaves on the accept edge, so the carry-in of 0 is folded in here.
                    ready_d = 1'b0;
                    frame_d = 1'b1;
                    line1_d = DATA1[0];
                    line2_d = DATA2[0];
                    sum_d   = DATA1[0] ^ DATA2[0];
                    carry_d = DATA1[0] & DATA2[0];
                    sh1_d   = DATA1 >> 1;
                    sh2_d   = DATA2 >> 1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (cnt == LAST) begin
                    done_d = 1'b1;
                    ovf_d  = carry;
                    gcnt_d = '0;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d   = cnt + 1'b1;
                    frame_d = 1'b1;
                    line1_d = sh1[0];
                    line2_d = sh2[0];
                    sum_d   = sh1[0] ^ sh2[0] ^ carry;
                    carry_d = (sh1[0] & sh2[0]) | (sh1[0] & carry) | (sh2[0] & carry);
                    sh1_d   = sh1 >> 1;
                    sh2_d   = sh2 >> 1;
                end
            end

            S_GAP: begin
                if (gcnt == GLAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gcnt_d = gcnt + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            gcnt        <= '0;
            sh1         <= '0;
            sh2         <= '0;
            carry       <= 1'b0;
            LOAD_READY  <= 1'b1;
            LINE1       <= 1'b0;
            LINE2       <= 1'b0;
            FRAME       <= 1'b0;
            EXP_SUM     <= 1'b0;
            EXP_OVERFLW <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            gcnt        <= gcnt_d;
            sh1         <= sh1_d;
            sh2         <= sh2_d;
            carry       <= carry_d;
            LOAD_READY  <= ready_d;
            LINE1       <= line1_d;
            LINE2       <= line2_d;
            FRAME       <= frame_d;
            EXP_SUM     <= sum_d;
            EXP_OVERFLW <= ovf_d;
            DONE        <= done_d;
        end
    end

endmodule

// File: tb/tb_b01_line_gen.sv
// Directed bench for b01_line_gen: three instances (W4/G2, W4/G0, W1/G0) share stimulus;
// expected per-cycle outputs come from integer addition of each accepted word pair.
module tb_b01_line_gen;

    typedef struct packed {
        logic ready;
        logic line1;
        logic line2;
        logic frame;
        logic sum;
        logic ovf;
        logic done;
    } exp_t;

    localparam int unsigned WV [3] = '{4, 4, 1};
    localparam int unsigned GV [3] = '{2, 0, 0};

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       LOAD_VALID = 1'b0;
    logic [3:0] DATA1 = '0;
    logic [3:0] DATA2 = '0;

    logic lr [3], l1 [3], l2 [3], fr [3], es [3], eo [3], dn [3];

    exp_t q [3][$];
    logic rdy [3];
    logic ovf_hold [3];
    int   checks = 0;
    int   errors = 0;

    always #5 CLOCK = ~CLOCK;

    b01_line_gen #(.WIDTH(4), .GAP(2)) u_w4g2 (
        .CLOCK(CLOCK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(lr[0]), .LINE1(l1[0]), .LINE2(l2[0]),
        .FRAME(fr[0]), .EXP_SUM(es[0]), .EXP_OVERFLW(eo[0]), .DONE(dn[0])
    );

    b01_line_gen #(.WIDTH(4), .GAP(0)) u_w4g0 (
        .CLOCK(CLOCK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(lr[1]), .LINE1(l1[1]), .LINE2(l2[1]),
        .FRAME(fr[1]), .EXP_SUM(es[1]), .EXP_OVERFLW(eo[1]), .DONE(dn[1])
    );

    b01_line_gen #(.WIDTH(1), .GAP(0)) u_w1g0 (
        .CLOCK(CLOCK), .RESET(RESET), .DATA1(DATA1[0]), .DATA2(DATA2[0]),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(lr[2]), .LINE1(l1[2]), .LINE2(l2[2]),
        .FRAME(fr[2]), .EXP_SUM(es[2]), .EXP_OVERFLW(eo[2]), .DONE(dn[2])
    );

    task automatic push_frame(input int i, input logic [3:0] a, input logic [3:0] b);
        int unsigned w;
        logic [4:0]  mask, am, bm, s;
        exp_t        e;
        w    = WV[i];
        mask = (5'd1 << w) - 5'd1;
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        s    = am + bm;
        for (int unsigned k = 0; k < w; k++) begin
            e = '0;
            e.line1 = am[k];
            e.line2 = bm[k];
            e.frame = 1'b1;
            e.sum   = s[k];
            q[i].push_back(e);
        end
        e = '0;
        e.ready = (GV[i] == 0);
        e.ovf   = s[w];
        e.done  = 1'b1;
        q[i].push_back(e);
        for (int unsigned g = 1; g < GV[i]; g++) begin
            e = '0;
            e.ovf = s[w];
            q[i].push_back(e);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input string tag);
        exp_t       e;
        logic [6:0] o;
        RESET      = rst;
        LOAD_VALID = v;
        DATA1      = a;
        DATA2      = b;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                q[i].delete();
                ovf_hold[i] = 1'b0;
            end else if (v && rdy[i]) begin
                push_frame(i, a, b);
            end
        end
        @(posedge CLOCK);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (q[i].size() > 0) begin
                e = q[i].pop_front();
            end else begin
                e = '0;
                e.ready = 1'b1;
                e.ovf   = ovf_hold[i];
            end
            rdy[i]      = e.ready;
            ovf_hold[i] = e.ovf;
            o = {lr[i], l1[i], l2[i], fr[i], es[i], eo[i], dn[i]};
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s inst%0d {rdy,l1,l2,frame,sum,ovf,done} observed=%b expected=%b",
                       tag, i, o, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rdy[i]      = 1'b0;
            ovf_hold[i] = 1'b0;
        end
        repeat (2) @(posedge CLOCK);
        #1;

        step(1'b1, 1'b0, 4'h0, 4'h0, "reset");
        repeat (5) step(1'b0, 1'b0, 4'h0, 4'h0, "idle");

        step(1'b0, 1'b1, 4'hB, 4'h6, "accept_b_6");
        repeat (8) step(1'b0, 1'b0, 4'h3, 4'h9, "frame_b_6");

        step(1'b0, 1'b1, 4'hF, 4'hF, "accept_f_f");
        repeat (8) step(1'b0, 1'b0, 4'h0, 4'h0, "frame_f_f");

        step(1'b0, 1'b1, 4'h0, 4'h0, "accept_0_0");
        repeat (8) step(1'b0, 1'b0, 4'hA, 4'h5, "frame_0_0");

        for (int n = 0; n < 24; n++) begin
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "valid_held");
        end
        repeat (8) step(1'b0, 1'b0, 4'h0, 4'h0, "drain");

        step(1'b0, 1'b1, 4'h7, 4'h3, "accept_pre_reset");
        step(1'b0, 1'b0, 4'h0, 4'h0, "mid_frame");
        step(1'b1, 1'b1, 4'hF, 4'hF, "reset_mid_frame");
        step(1'b0, 1'b0, 4'h0, 4'h0, "post_reset_idle");

        step(1'b0, 1'b1, 4'h1, 4'h1, "accept_after_reset");
        repeat (8) step(1'b0, 1'b0, 4'hE, 4'hE, "frame_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/b01_line_gen.md
Name: b01_line_gen

Overview:
- Stimulus-side counterpart of the b01 serial-flow comparator: the comparator receives LINE1/LINE2; this block drives them.
- Accepts a pair of parallel words over a valid/ready handshake and shifts both out LSB-first, one bit per clock, on LINE1/LINE2.
- Also emits a golden serial sum and a final carry, so the comparator's OUTP/OVERFLW can be checked bit by bit.
- Sits between the test sequencer and the comparator inputs.

Parameters:
- WIDTH, 8, bits per word and serial frame length (legal: WIDTH >= 1).
- GAP, 1, idle cycles after each frame before LOAD_READY returns (legal: GAP >= 0).

Ports:
- CLOCK  in  1  single clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA1  in  WIDTH  word serialised onto LINE1.
- DATA2  in  WIDTH  word serialised onto LINE2.
- LOAD_VALID  in  1  DATA1/DATA2 valid.
- LOAD_READY  out  1  block idle; can accept a word pair.
- LINE1  out  1  serial stream 1.
- LINE2  out  1  serial stream 2.
- FRAME  out  1  high while LINE1/LINE2 carry data bits.
- EXP_SUM  out  1  golden serial sum bit for the current bit position.
- EXP_OVERFLW  out  1  final carry of DATA1+DATA2; valid from the DONE cycle onward.
- DONE  out  1  one-cycle pulse after the last data bit.

Behaviour:
- All outputs are registered.
- Reset (RESET=1 at an edge):
  - state=IDLE, LOAD_READY=1 on the next cycle.
  - LINE1, LINE2, FRAME, EXP_SUM, EXP_OVERFLW, DONE all 0.
  - Bit counter and carry cleared.
  - Reset overrides every other input. Asserted mid-frame, it drops the frame immediately and emits no DONE.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - LOAD_READY=1, FRAME=0, LINE1/LINE2=0.
  - Accept occurs at edge T when LOAD_VALID=1: capture DATA1 and DATA2, clear the carry, go to SHIFT.
- Handshake: LOAD_READY is 1 only in IDLE. LOAD_VALID in any other state is ignored and DATA1/DATA2 are not sampled.
- SHIFT, cycles T+1 .. T+WIDTH; in cycle T+1+k (k = 0..WIDTH-1):
  - LINE1=DATA1[k], LINE2=DATA2[k], FRAME=1, LOAD_READY=0.
  - EXP_SUM = DATA1[k] ^ DATA2[k] ^ c, where c is the carry into bit k (0 for k=0).
  - Carry updated to majority(DATA1[k], DATA2[k], c).
- Cycle T+WIDTH+1:
  - FRAME=0, LINE1/LINE2=0, EXP_SUM=0.
  - DONE=1 for exactly this cycle.
  - EXP_OVERFLW = carry out of bit WIDTH-1. It is held until the next accept, then cleared to 0 on that accept.
- GAP:
  - Occupies GAP cycles starting at T+WIDTH+1, with lines held 0 and LOAD_READY=0.
  - LOAD_READY returns to 1 in cycle T+WIDTH+1+GAP.
  - GAP=0: the block is in IDLE with LOAD_READY=1 in the same cycle as DONE, so back-to-back frames are separated by exactly one idle cycle.
- Minimum frame-to-frame period is WIDTH+1+GAP cycles after the accept.
- Bit counter is ceil(log2(WIDTH+1)) bits wide and never wraps within a frame. The transition SHIFT->GAP/IDLE happens when counter == WIDTH-1.
- WIDTH=1: a single SHIFT cycle, and DONE follows it directly.
- The captured words are immune to DATA1/DATA2 changes after the accept.

Test Plan:
- Reset, then idle for 5 cycles with LOAD_VALID=0:
  - LOAD_READY=1, all other outputs 0 throughout.
- WIDTH=4, GAP=2, DATA1=0xB, DATA2=0x6, accept at T:
  - LINE1 = 1,1,0,1; LINE2 = 0,1,1,0; EXP_SUM = 1,0,0,0; FRAME=1 in T+1..T+4.
  - DONE=1 and EXP_OVERFLW=1 at T+5.
  - LOAD_READY=1 at T+7.
- WIDTH=4, DATA1=0xF, DATA2=0xF:
  - EXP_SUM = 0,1,1,1; EXP_OVERFLW=1.
- Then DATA1=0x0, DATA2=0x0:
  - EXP_OVERFLW clears at the accept; EXP_SUM all 0; EXP_OVERFLW=0 at DONE.
- GAP=0, LOAD_VALID held at 1 with changing data:
  - Frames start every WIDTH+1 cycles; DONE and LOAD_READY coincide.
  - Data changes during SHIFT do not affect LINE1/LINE2.
- RESET asserted in cycle T+2 of a frame:
  - Next cycle: FRAME=0, lines 0, no DONE, LOAD_READY=1.
  - A new accept then proceeds normally, with the carry starting at 0.
